// File: rtl/frame_pattern_gen.sv
// Test-pattern frame generator: walks x/y over an H_ACTIVE x V_ACTIVE frame and
// presents one pixel per cycle on a valid/ready write port.
module frame_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DATA_W   = 8,
    parameter int BAR_LOG2 = 6,
    parameter int FCNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    input  logic [2:0]        mode,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [DATA_W-1:0] wr_data,
    output logic [15:0]       wr_x,
    output logic [15:0]       wr_y,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              done,
    output logic [FCNT_W-1:0] frame_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);
    localparam logic [15:0] X_HALF = 16'(H_ACTIVE / 2);
    localparam logic [15:0] Y_HALF = 16'(V_ACTIVE / 2);

    localparam longint unsigned PIX_MAX_L = (longint'(1) << DATA_W) - 1;
    localparam logic [DATA_W-1:0] PIX_MAX        = '1;
    localparam logic [DATA_W-1:0] PIX_THIRD      = DATA_W'(PIX_MAX_L / 3);
    localparam logic [DATA_W-1:0] PIX_TWO_THIRDS = DATA_W'((2 * PIX_MAX_L) / 3);

    state_t            state_q, state_d;
    logic [15:0]       x_q, x_d;
    logic [15:0]       y_q, y_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [2:0]        mode_q, mode_d;
    logic              stop_pend_q, stop_pend_d;

    logic              xfer;
    logic              last_x;
    logic              last_px;
    logic [15:0]       xy;
    logic [DATA_W-1:0] pix;

    assign xfer    = (state_q == ST_RUN) && wr_ready;
    assign last_x  = (x_q == X_LAST);
    assign last_px = last_x && (y_q == Y_LAST);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        fcnt_d      = fcnt_q;
        mode_d      = mode_q;
        stop_pend_d = stop_pend_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    x_d         = '0;
                    y_d         = '0;
                    fcnt_d      = '0;
                    mode_d      = mode;
                    stop_pend_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop) stop_pend_d = 1'b1;
                if (xfer) begin
                    if (last_x) begin
                        x_d = '0;
                        y_d = y_q + 16'd1;
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                    if (last_px) begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                        y_d    = '0;
                        // a stop arriving with the last pixel still ends the run
                        if (continuous && !stop_pend_q && !stop) mode_d = mode;
                        else                                      state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            fcnt_q      <= '0;
            mode_q      <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            fcnt_q      <= fcnt_d;
            mode_q      <= mode_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Pixel value is purely a function of registered position, so it holds during stalls
    always_comb begin
        pix = '0;
        xy  = x_q ^ y_q;
        unique case (mode_q)
            3'd0: begin
                if (y_q < Y_HALF) pix = (x_q < X_HALF) ? '0 : PIX_THIRD;
                else              pix = (x_q < X_HALF) ? PIX_TWO_THIRDS : PIX_MAX;
            end
            3'd1:    pix = x_q[BAR_LOG2] ? PIX_MAX : '0;
            3'd2:    pix = y_q[BAR_LOG2] ? PIX_MAX : '0;
            3'd3:    pix = xy[BAR_LOG2] ? PIX_MAX : '0;
            3'd4:    pix = DATA_W'(x_q);
            3'd5:    pix = DATA_W'(fcnt_q);
            3'd6:    pix = PIX_MAX;
            default: pix = '0;
        endcase
    end

    assign wr_valid    = (state_q == ST_RUN);
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign wr_data     = wr_valid ? pix : '0;
    assign wr_x        = x_q;
    assign wr_y        = y_q;
    assign sof         = wr_valid && (x_q == 16'd0) && (y_q == 16'd0);
    assign eol         = wr_valid && last_x;
    assign frame_count = fcnt_q;

endmodule

// File: doc/frame_pattern_gen.md
FRAME_PATTERN_GEN -- requirements
Module: frame_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, pixels per line (>=2).
REQ-002 SHALL have parameter V_ACTIVE, default 480, lines per frame (>=2).
REQ-003 SHALL have parameter DATA_W, default 8, pixel width in bits (>=2).
REQ-004 SHALL have parameter BAR_LOG2, default 6, log2 of bar/checker cell size in pixels.
REQ-005 SHALL have parameter FCNT_W, default 8, frame counter width.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  single-cycle request to begin generation; honoured only in IDLE or DONE.
REQ-009 continuous  input  1  sampled at each frame end; 1 = start another frame.
REQ-010 stop  input  1  pulse; ends continuous run after the current frame.
REQ-011 mode  input  3  pattern select, latched at start and at every frame start.
REQ-012 wr_valid  output  1  pixel on wr_data/wr_x/wr_y is valid.
REQ-013 wr_ready  input  1  sink accepts pixel; transfer = wr_valid & wr_ready.
REQ-014 wr_data  output  DATA_W  pixel value.
REQ-015 wr_x, wr_y  output  16 each  pixel coordinates of the current pixel.
REQ-016 sof, eol  output  1 each  first pixel of frame / last pixel of line, qualified by wr_valid.
REQ-017 busy, done  output  1 each  in RUN / in DONE.
REQ-018 frame_count  output  FCNT_W  frames fully transferred since last start; wraps modulo 2^FCNT_W.

Function
REQ-019 States SHALL be IDLE, RUN, DONE; one-hot or encoded at implementer's choice.
REQ-020 IDLE->RUN on start; x=y=0, frame_count=0, mode latched, stop_pending cleared.
REQ-021 RUN: wr_valid=1 every cycle; x,y advance only on transfer; x wraps H_ACTIVE-1->0 with y+1.
REQ-022 Last pixel (x=H_ACTIVE-1, y=V_ACTIVE-1) transferred: frame_count+1; if continuous=1 and no stop_pending then x=y=0, mode relatched, stay RUN (no bubble); else ->DONE.
REQ-023 stop SHALL set stop_pending in RUN; stop in the same cycle as the last-pixel transfer counts.
REQ-024 DONE: wr_valid=0, done=1, frame_count held; start ->RUN as in REQ-020.
REQ-025 start while in RUN SHALL be ignored.
REQ-026 wr_data, wr_x, wr_y, sof, eol SHALL stay stable while wr_valid=1 and wr_ready=0.
REQ-027 wr_data/sof/eol SHALL be combinational from registered x, y, latched mode, frame_count; zero when wr_valid=0.
REQ-028 Patterns (M=2^DATA_W-1): mode0 quadrants: x<H/2,y<V/2 ->0; right-top ->M/3; left-bottom ->2M/3 (integer); right-bottom ->M.
REQ-029 mode1 vertical bars: M if bit BAR_LOG2 of x set, else 0; mode2 horizontal bars: same on y.
REQ-030 mode3 checkerboard: M if bit BAR_LOG2 of (x XOR y) set, else 0.
REQ-031 mode4 ramp: x[DATA_W-1:0]; mode5 frame tag: frame_count zero-extended/truncated to DATA_W.
REQ-032 mode6 solid M; mode7 SHALL output 0.
REQ-033 H/2, V/2 SHALL use integer division (odd sizes: extra column/row belongs to right/bottom).

Reset
REQ-034 reset SHALL force IDLE, x=y=0, frame_count=0, stop_pending=0, latched mode=0 next cycle.
REQ-035 During/after reset: wr_valid, sof, eol, busy, done=0, wr_data=0; reset mid-frame discards frame, no partial count.
REQ-036 reset SHALL dominate start in the same cycle.

Verification
REQ-037 H=8,V=4,DATA_W=8,mode0, wr_ready=1, start pulse -> 32 transfers, values 0,85,170,255 by quadrant, sof on pixel 0, eol on x=7, then done=1, frame_count=1.
REQ-038 Same, wr_ready toggled randomly -> exactly 32 transfers, same sequence, outputs stable during every stall.
REQ-039 continuous=1, mode5, 3 frames then stop pulse mid-frame 3 -> back-to-back frames, wr_data=0,1,2 per frame, DONE after frame 3, frame_count=3.
REQ-040 Reset asserted at pixel 10 of frame -> next cycle wr_valid=0, busy=0, frame_count=0; subsequent start restarts at (0,0).
REQ-041 mode3, BAR_LOG2=1, H=8,V=4 -> checker of 2x2 cells, pixel (2,0)=255, (2,2)=0; start during RUN has no effect.
REQ-042 Odd sizes H=7,V=3, mode0 -> column 3 and row 1 use right/bottom quadrant values; 21 transfers total.
